seg7_scan_driver: RTL and testbench

//   Downstream stage of the BCD-to-7-segment path: takes a packed multi-digit BCD word on a load

---
 rtl/seg7_scan_driver.sv | 184 ++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-cathode 7-segment driver: double-buffered BCD word,
// per-digit decode, optional leading-zero blanking and invalid-code flag.
module seg7_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   Din,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done,
    output logic                  err
);

    localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam int IW = $clog2(DIGITS);
    localparam int DW = 4 * DIGITS;
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    function automatic logic any_invalid(input logic [DW-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DW-1:0]     act_q, act_d;
    logic [DW-1:0]     pend_q, pend_d;
    logic              act_blz_q, act_blz_d;
    logic              pend_blz_q, pend_blz_d;
    logic              pend_vld_q, pend_vld_d;
    logic              err_q, err_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic              fd_q, fd_d;

    logic              wrap_s;
    logic              commit_s;
    logic [3:0]        cur_s;
    logic [DIGITS-1:0] lz_s;
    logic              above_zero_s;

    assign wrap_s   = (cnt_q == CNT_LAST);
    assign commit_s = wrap_s && (idx_q == IDX_LAST);

    // State register for scan position, buffers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            act_q      <= '0;
            pend_q     <= '0;
            act_blz_q  <= 1'b0;
            pend_blz_q <= 1'b0;
            pend_vld_q <= 1'b0;
            err_q      <= 1'b0;
            seg_q      <= 7'h00;
            an_q       <= '0;
            fd_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            act_q      <= act_d;
            pend_q     <= pend_d;
            act_blz_q  <= act_blz_d;
            pend_blz_q <= pend_blz_d;
            pend_vld_q <= pend_vld_d;
            err_q      <= err_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
            fd_q       <= fd_d;
        end
    end

    // Next-state: scan counters, pending capture and frame-boundary commit
    always_comb begin
        cnt_d      = wrap_s ? CW'(0) : cnt_q + CW'(1);
        idx_d      = idx_q;
        act_d      = act_q;
        act_blz_d  = act_blz_q;
        pend_d     = pend_q;
        pend_blz_d = pend_blz_q;
        pend_vld_d = pend_vld_q;
        err_d      = err_q;
        if (wrap_s) begin
            idx_d = (idx_q == IDX_LAST) ? IW'(0) : idx_q + IW'(1);
        end else begin
            idx_d = idx_q;
        end
        if (load) begin
            pend_d     = Din;
            pend_blz_d = blank_lz;
            pend_vld_d = 1'b1;
        end else begin
            pend_vld_d = pend_vld_q;
        end
        // A load on the commit edge bypasses the pending buffer
        if (commit_s) begin
            if (load) begin
                act_d     = Din;
                act_blz_d = blank_lz;
            end else if (pend_vld_q) begin
                act_d     = pend_q;
                act_blz_d = pend_blz_q;
            end else begin
                act_d     = act_q;
            end
            pend_vld_d = 1'b0;
            err_d      = any_invalid(act_d);
        end else begin
            err_d = err_q;
        end
    end

    // Output decode for the slot position currently held in the counters
    always_comb begin
        cur_s        = 4'd0;
        an_d         = '0;
        lz_s         = '0;
        above_zero_s = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_s   = act_q[4*i +: 4];
                an_d[i] = 1'b1;
            end else begin
                an_d[i] = 1'b0;
            end
        end
        // Any nonzero code, valid or not, ends the run of leading zeros
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (act_q[4*i +: 4] != 4'd0) begin
                above_zero_s = 1'b0;
            end else begin
                above_zero_s = above_zero_s;
            end
            lz_s[i] = above_zero_s;
        end
        if (cnt_q == CW'(0)) begin
            an_d  = '0;
            seg_d = 7'h00;
        end else if (act_blz_q && lz_s[idx_q]) begin
            seg_d = 7'h00;
        end else begin
            seg_d = decode(cur_s);
        end
        fd_d = commit_s;
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = fd_q;
    assign err        = err_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a frame-level reference model
// checked every cycle, plus literal per-digit frame captures.
module tb_seg7_scan_driver;

    localparam int D = 4;
    localparam int P = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [15:0] Din = 16'h0000;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    seg7_scan_driver #(.DIGITS(D), .PRESCALE(P)) dut (
        .clk(clk), .rst(rst), .load(load), .Din(Din), .blank_lz(blank_lz),
        .seg(seg), .an(an), .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dec(input int c);
        case (c)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    function automatic int digit_of(input logic [15:0] v, input int i);
        return int'(v[4*i +: 4]);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: edge count since reset selects slot/phase; frames swap on multiples of D*P
    int          edge_n = 0;
    int          ph, dg, msd;
    logic [15:0] m_disp, m_pend;
    logic        m_blz, m_pblz, m_pv, m_err;
    logic [6:0]  e_seg;
    logic [3:0]  e_an;
    logic        e_fd, e_err;
    bit          model_on = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            edge_n = 0; m_disp = 16'h0; m_pend = 16'h0;
            m_blz = 1'b0; m_pblz = 1'b0; m_pv = 1'b0; m_err = 1'b0;
            e_seg = 7'h00; e_an = 4'h0; e_fd = 1'b0; e_err = 1'b0;
        end else begin
            edge_n++;
            ph = (edge_n - 1) % P;
            dg = ((edge_n - 1) / P) % D;
            msd = 0;
            for (int i = 0; i < D; i++) if (digit_of(m_disp, i) != 0) msd = i;
            if (ph == 0) begin
                e_an = 4'h0; e_seg = 7'h00;
            end else begin
                e_an  = 4'(1 << dg);
                e_seg = (m_blz && dg > msd) ? 7'h00 : dec(digit_of(m_disp, dg));
            end
            e_fd = (edge_n % (D * P) == 0);
            if (e_fd) begin
                if (load) begin
                    m_disp = Din; m_blz = blank_lz;
                end else if (m_pv) begin
                    m_disp = m_pend; m_blz = m_pblz;
                end
                m_pv = 1'b0;
                m_err = 1'b0;
                for (int i = 0; i < D; i++) if (digit_of(m_disp, i) > 9) m_err = 1'b1;
            end else if (load) begin
                m_pend = Din; m_pblz = blank_lz; m_pv = 1'b1;
            end
            e_err = m_err;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("seg", 32'(seg), 32'(e_seg));
            chk("an", 32'(an), 32'(e_an));
            chk("frame_done", 32'(frame_done), 32'(e_fd));
            chk("err", 32'(err), 32'(e_err));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v, input logic b);
        load = 1'b1; Din = v; blank_lz = b;
        step();
        load = 1'b0;
    endtask

    // Records the lit segment value of each digit in the frame after the next frame_done
    task automatic capture_frame(output logic [27:0] s, output logic [3:0] seen);
        int guard;
        s = '0; seen = '0; guard = 0;
        @(negedge clk);
        while (!frame_done && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!frame_done) begin
            n_checks++; n_errors++;
            $display("FAIL frame_wait: got no frame_done expected pulse within 40 cycles");
        end
        for (int k = 0; k < D * P; k++) begin
            @(negedge clk);
            for (int i = 0; i < D; i++) begin
                if (an == 4'(1 << i)) begin
                    s[7*i +: 7] = seg;
                    seen[i] = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic chk_frame(input string nm, input logic [27:0] s, input logic [3:0] seen,
                             input logic [6:0] d0, input logic [6:0] d1,
                             input logic [6:0] d2, input logic [6:0] d3);
        chk({nm, "_d0"}, 32'(s[6:0]), 32'(d0));
        chk({nm, "_d1"}, 32'(s[13:7]), 32'(d1));
        chk({nm, "_d2"}, 32'(s[20:14]), 32'(d2));
        chk({nm, "_d3"}, 32'(s[27:21]), 32'(d3));
        chk({nm, "_an"}, 32'(seen), 32'h0000000F);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [27:0] fr;
        logic [3:0]  sn;
        int cnt;

        // Reset held, then release; first frame_done lands 16 cycles later
        repeat (3) @(negedge clk);
        model_on = 1'b1;
        #1;
        chk("rst_seg", 32'(seg), 32'h0);
        chk("rst_an", 32'(an), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        rst = 1'b0;
        for (int r = 0; r < 2; r++) begin
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
            end while (!frame_done && cnt < 40);
            chk("fd_period", 32'(cnt), 32'd16);
        end
        #1;

        // Mid-frame load of 1234
        repeat (5) step();
        do_load(16'h1234, 1'b0);
        capture_frame(fr, sn);
        chk_frame("f1234", fr, sn, 7'h66, 7'h4F, 7'h5B, 7'h06);

        // Leading-zero blanking
        do_load(16'h0050, 1'b1);
        capture_frame(fr, sn);
        chk_frame("f0050", fr, sn, 7'h3F, 7'h6D, 7'h00, 7'h00);
        do_load(16'h0000, 1'b1);
        capture_frame(fr, sn);
        chk_frame("f0000", fr, sn, 7'h3F, 7'h00, 7'h00, 7'h00);

        // Invalid code, then recovery
        do_load(16'h12A4, 1'b1);
        capture_frame(fr, sn);
        chk_frame("f12A4", fr, sn, 7'h66, 7'h40, 7'h5B, 7'h06);
        chk("err_set", 32'(err), 32'h1);
        do_load(16'h5555, 1'b0);
        capture_frame(fr, sn);
        chk_frame("f5555", fr, sn, 7'h6D, 7'h6D, 7'h6D, 7'h6D);
        chk("err_clr", 32'(err), 32'h0);

        // Two loads in one frame: last wins
        do_load(16'h1111, 1'b0);
        repeat (2) step();
        do_load(16'h2222, 1'b0);
        capture_frame(fr, sn);
        chk_frame("f2222", fr, sn, 7'h5B, 7'h5B, 7'h5B, 7'h5B);

        // Pending 1111 overridden by a load on the commit edge
        repeat (3) step();
        do_load(16'h1111, 1'b0);
        cnt = 0;
        while (((edge_n + 1) % (D * P)) != 0 && cnt < 40) begin
            step();
            cnt++;
        end
        do_load(16'h3456, 1'b0);
        capture_frame(fr, sn);
        chk_frame("f3456", fr, sn, 7'h7D, 7'h6D, 7'h66, 7'h4F);

        // Reset during digit-2 slot with a pending load
        do_load(16'h0A00, 1'b0);
        capture_frame(fr, sn);
        chk("err_pre_rst", 32'(err), 32'h1);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (an != 4'b0100 && cnt < 40);
        chk("slot2_seen", 32'(an), 32'h4);
        #1;
        do_load(16'h9999, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_seg", 32'(seg), 32'h0);
        chk("mid_rst_an", 32'(an), 32'h0);
        chk("mid_rst_err", 32'(err), 32'h0);
        chk("mid_rst_fd", 32'(frame_done), 32'h0);
        repeat (2) step();
        rst = 1'b0;
        capture_frame(fr, sn);
        chk_frame("f_post_rst", fr, sn, 7'h3F, 7'h3F, 7'h3F, 7'h3F);
        chk("err_post_rst", 32'(err), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
